// File: rtl/timer_ctrl.sv
// ----------------------------------------------------------------------------
// timer_ctrl
//   Programmable interval timer for the interrupt controller's timer request.
//   A 7-bit down-counter advances once every PRESCALE clk cycles while enabled.
//   When it underflows it reloads from the reload register and latches a
//   pending request, which is presented active-low on TIQ_n until TIQ_ack.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high; clears all state
//   RDY      bus ready; qualifies register writes
//   re       read strobe
//   we       write strobe
//   CET_n    timer chip-select, active-low
//   addr     0 = counter (read) / reload (write), 1 = control (bit 0 = enable)
//   dIn      write data
//   dOut     combinational read data, 0 when not selected for read
//   TIQ_n    timer interrupt request, active-low
//   TIQ_ack  clears the pending request (an underflow in the same cycle wins)
// ----------------------------------------------------------------------------
module timer_ctrl #(
   parameter int PRESCALE = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RDY,
   input  logic       re,
   input  logic       we,
   input  logic       CET_n,
   input  logic       addr,
   input  logic [7:0] dIn,
   output logic [7:0] dOut,
   output logic       TIQ_n,
   input  logic       TIQ_ack
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [6:0]    reload_reg, reload_next;
   logic [6:0]    count_reg,  count_next;
   logic          en_reg,     en_next;
   logic          pend_reg,   pend_next;
   logic [PW-1:0] pre_reg,    pre_next;

   logic wr;
   logic en_edge;
   logic tick;
   logic underflow;

   assign wr        = RDY & ~CET_n & we;
   // Only a 0->1 transition of the enable bit restarts the counter.
   assign en_edge   = wr & addr & dIn[0] & ~en_reg;
   assign tick      = en_reg & (pre_reg == PRE_LAST);
   assign underflow = tick & (count_reg == 7'd0);

   always_comb begin
      reload_next = reload_reg;
      count_next  = count_reg;
      en_next     = en_reg;
      pre_next    = pre_reg;
      pend_next   = pend_reg;

      if (wr & ~addr)
         reload_next = dIn[6:0];
      if (wr & addr)
         en_next = dIn[0];

      // The counter always loads the reload value held before this edge, so
      // a reload write coinciding with an underflow only affects the next period.
      if (en_edge) begin
         count_next = reload_reg;
         pre_next   = '0;
      end else if (en_reg) begin
         pre_next = tick ? '0 : pre_reg + PW'(1);
         if (tick)
            count_next = underflow ? reload_reg : count_reg - 7'd1;
      end

      // Set dominates clear so no underflow event is lost to a coincident ack.
      if (underflow)
         pend_next = 1'b1;
      else if (TIQ_ack)
         pend_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reload_reg <= '0;
         count_reg  <= '0;
         en_reg     <= 1'b0;
         pre_reg    <= '0;
         pend_reg   <= 1'b0;
      end else begin
         reload_reg <= reload_next;
         count_reg  <= count_next;
         en_reg     <= en_next;
         pre_reg    <= pre_next;
         pend_reg   <= pend_next;
      end
   end

   always_comb begin
      dOut = 8'h00;
      if (~CET_n & re)
         dOut = addr ? {7'b0, en_reg} : {1'b0, count_reg};
   end

   assign TIQ_n = ~pend_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_timer_ctrl
//   Scoreboard bench for timer_ctrl with PRESCALE = 4. The driver applies one
//   bus cycle per clock, pushes the expected dOut/TIQ_n for that cycle, then
//   advances a reference model that tracks elapsed running cycles within the
//   current period. A monitor pops and compares every cycle.
// ----------------------------------------------------------------------------
module tb_timer_ctrl;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       RDY, re, we, CET_n, addr, TIQ_ack;
   logic [7:0] dIn;
   logic [7:0] dOut;
   logic       TIQ_n;

   timer_ctrl #(.PRESCALE(P)) dut (
      .clk     (clk),
      .reset   (reset),
      .RDY     (RDY),
      .re      (re),
      .we      (we),
      .CET_n   (CET_n),
      .addr    (addr),
      .dIn     (dIn),
      .dOut    (dOut),
      .TIQ_n   (TIQ_n),
      .TIQ_ack (TIQ_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       chk_dout;
      logic [7:0] dout;
      logic       tiq_n;
      int         cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Reference model: period length is (loaded+1)*P running cycles; the
   // visible count is loaded minus completed prescaler periods.
   int m_reload, m_loaded, m_elapsed;
   bit m_en, m_pend;

   function automatic int m_count();
      return m_loaded - (m_elapsed / P);
   endfunction

   function automatic bit m_uf_next();
      return m_en && ((m_elapsed + 1) == (m_loaded + 1) * P);
   endfunction

   task automatic model_reset();
      m_reload = 0; m_loaded = 0; m_elapsed = 0; m_en = 0; m_pend = 0;
   endtask

   task automatic model_step(input bit r, input bit rdy, input bit w, input bit cs_n,
                             input bit a, input logic [7:0] d, input bit ack);
      bit wr_q, uf;
      if (r) begin
         model_reset();
         return;
      end
      wr_q = rdy && !cs_n && w;
      uf   = 0;
      if (wr_q && a && d[0] && !m_en) begin
         m_loaded  = m_reload;
         m_elapsed = 0;
      end else if (m_en) begin
         m_elapsed++;
         if (m_elapsed == (m_loaded + 1) * P) begin
            uf        = 1;
            m_loaded  = m_reload;
            m_elapsed = 0;
         end
      end
      if (uf)       m_pend = 1;
      else if (ack) m_pend = 0;
      if (wr_q && !a) m_reload = int'(d[6:0]);
      if (wr_q && a)  m_en     = d[0];
   endtask

   // One bus cycle: drive at negedge, record expectation, model at posedge.
   task automatic cyc_drive(input bit r, input bit rdy, input bit rd, input bit w,
                            input bit cs_n, input bit a, input logic [7:0] d,
                            input bit ack);
      exp_t e;
      @(negedge clk);
      reset = r; RDY = rdy; re = rd; we = w; CET_n = cs_n; addr = a;
      dIn = d; TIQ_ack = ack;
      e.chk_dout = 1'b1;
      if (!cs_n && rd) e.dout = a ? {7'b0, m_en} : {1'b0, 7'(m_count())};
      else             e.dout = 8'h00;
      e.tiq_n = !m_pend;
      e.cyc   = cyc;
      sb_q.push_back(e);
      @(posedge clk);
      model_step(r, rdy, w, cs_n, a, d, ack);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_drive(0, 1, 1, 0, 0, 0, 8'h00, 0);
   endtask

   task automatic wr_reg(input bit a, input logic [7:0] d);
      cyc_drive(0, 1, 0, 1, 0, a, d, 0);
   endtask

   task automatic direct_check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: compares the DUT against each queued expectation mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (dOut !== e.dout || TIQ_n !== e.tiq_n) begin
               n_fail++;
               $display("FAIL cycle %0d: dOut=%h TIQ_n=%b, expected dOut=%h TIQ_n=%b",
                        e.cyc, dOut, TIQ_n, e.dout, e.tiq_n);
            end else begin
               $display("cycle %0d: dOut=%h TIQ_n=%b ok", e.cyc, dOut, TIQ_n);
            end
         end
      end
   end

   initial begin
      int n;
      bit r, rdy, rd, w, cs_n, a, ack;
      logic [7:0] d;
      int sel;

      reset = 1; RDY = 0; re = 0; we = 0; CET_n = 1; addr = 0; dIn = 0; TIQ_ack = 0;
      model_reset();
      repeat (3) @(posedge clk);

      // 1: reset state and reads
      cyc_drive(1, 1, 1, 0, 0, 0, 8'h00, 0);
      cyc_drive(0, 1, 1, 0, 0, 0, 8'h00, 0);
      cyc_drive(0, 1, 1, 0, 0, 1, 8'h00, 0);

      // 2: reload=2, enable, IRQ 12 clk after the enable edge
      wr_reg(0, 8'h02);
      wr_reg(1, 8'h01);
      n = 0;
      do begin
         idle(1);
         n++;
         #1;
      end while (TIQ_n !== 1'b0 && n < 40);
      direct_check("first_irq_latency", n, 12);
      idle(14);

      // 3: ack clears, next underflow re-raises
      cyc_drive(0, 1, 1, 0, 0, 0, 8'h00, 1);
      idle(14);

      // 4: ack in the underflow cycle keeps the request
      cyc_drive(0, 1, 1, 0, 0, 0, 8'h00, 1);
      n = 0;
      while (!m_uf_next() && n < 40) begin idle(1); n++; end
      direct_check("uf_found", int'(m_uf_next()), 1);
      cyc_drive(0, 1, 1, 0, 0, 0, 8'h00, 1);
      idle(2);
      direct_check("ack_vs_uf_tiq", int'(TIQ_n), 0);

      // 5: disable with count=1, hold 50 clk, re-enable
      cyc_drive(0, 1, 1, 0, 0, 0, 8'h00, 1);
      n = 0;
      while (!(m_count() == 1 && (m_elapsed % P) == 1) && n < 40) begin idle(1); n++; end
      wr_reg(1, 8'h00);
      idle(50);
      wr_reg(1, 8'h01);
      idle(14);

      // 6: reload=0 -> IRQ every 4 clk; RDY=0 write of en=0 is ignored
      wr_reg(0, 8'h00);
      idle(16);
      cyc_drive(0, 0, 0, 1, 0, 1, 8'h00, 0);
      cyc_drive(0, 1, 1, 0, 0, 1, 8'h00, 1);
      idle(10);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         sel  = $urandom_range(0, 99);
         r    = ($urandom_range(0, 599) == 0);
         rdy  = ($urandom_range(0, 9) != 0);
         cs_n = ($urandom_range(0, 9) == 0);
         rd   = $urandom_range(0, 1);
         a    = $urandom_range(0, 1);
         w    = 0;
         ack  = 0;
         d    = 8'($urandom_range(0, 255));
         if (sel < 3) begin
            w = 1; a = 0; d = {d[7:3] & 5'h10, d[2:0]};
         end else if (sel < 7) begin
            w = 1; a = 1;
         end else if (sel < 12) begin
            ack = 1;
         end
         cyc_drive(r, rdy, rd, w, cs_n, a, d, ack);
      end

      idle(2);
      @(negedge clk);
      #4;
      direct_check("scoreboard_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
